handshake_const_compare: RTL

Elastic comparator: consumes data tokens, compares each against a compile-time constant, and emits one 1-bit condition token per input token. It is the consuming counterpart of the constant-producing handshake components: where those turn a control token into a constant data token, this block turns a data token into a control/condition token. The output is buffered through a 2-slot FIFO, so both `ins_ready` and `outs_valid` are driven from registers and throughput is one token per cycle. It sits between a datapath producer and a branch or mux condition input.

---
 rtl/handshake_const_compare.sv | 84 ++++++++
 1 files changed

// File: rtl/handshake_const_compare.sv
// Elastic comparator: each accepted data token becomes a 1-bit condition token
// (ins == CONST_VALUE), buffered through a 2-slot FIFO with registered handshakes.
module handshake_const_compare #(
    parameter int unsigned              DATA_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0]    CONST_VALUE = 16'b0100001111100010
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic                  outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [15:0]           match_count
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e      state_q, state_d;
    logic        wp_q, wp_d;
    logic        rp_q, rp_d;
    logic [1:0]  mem_q, mem_d;
    logic [15:0] match_count_q, match_count_d;
    logic        push, pop, cond;

    // Handshake outputs come straight from registers; no ready pass-through.
    assign ins_ready   = (state_q != StFull);
    assign outs_valid  = (state_q != StEmpty);
    assign outs        = mem_q[rp_q];
    assign match_count = match_count_q;

    always_comb begin
        cond          = (ins == CONST_VALUE);
        push          = ins_valid & ins_ready;
        pop           = outs_valid & outs_ready;
        state_d       = state_q;
        wp_d          = wp_q;
        rp_d          = rp_q;
        mem_d         = mem_q;
        match_count_d = match_count_q;

        if (push) begin
            mem_d[wp_q] = cond;
            wp_d        = ~wp_q;
        end
        if (pop) begin
            rp_d = ~rp_q;
            if (outs) begin
                match_count_d = match_count_q + 16'd1;
            end
        end

        unique case (state_q)
            StEmpty: if (push) state_d = StOne;
            StOne: begin
                if (push && !pop) begin
                    state_d = StFull;
                end else if (pop && !push) begin
                    state_d = StEmpty;
                end
            end
            StFull:  if (pop) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StEmpty;
            wp_q          <= 1'b0;
            rp_q          <= 1'b0;
            mem_q         <= 2'b00;
            match_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            wp_q          <= wp_d;
            rp_q          <= rp_d;
            mem_q         <= mem_d;
            match_count_q <= match_count_d;
        end
    end

endmodule
